// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames scan-code set 2 bytes and tracks the currently held key.
// Handles make, F0 break and E0 extended prefixes; aborts stalled frames after a timeout.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic [7:0] key,
  output logic       key_ext,
  output logic       key_make,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall_c;
  logic                   dat_c;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [7:0]  code_q, code_d;
  logic        code_valid_q, code_valid_d;
  logic [7:0]  key_q, key_d;
  logic        key_ext_q, key_ext_d;
  logic        key_make_q, key_make_d;
  logic        frame_err_q, frame_err_d;

  // Synchronisers; reset to the idle-high level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kb_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign dat_c  = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      key_q        <= '0;
      key_ext_q    <= 1'b0;
      key_make_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      key_q        <= key_d;
      key_ext_q    <= key_ext_d;
      key_make_q   <= key_make_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame FSM, timeout and key tracking; a detected falling edge beats the timeout
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    key_d        = key_q;
    key_ext_d    = key_ext_q;
    key_make_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (fall_c) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_c) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d  = {dat_c, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'(1);
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_c;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_c && (^{shift_q, parity_q})) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
            if (shift_q == BYTE_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == BYTE_BRK) begin
              brk_d = 1'b1;
            end else if (brk_q) begin
              if ((shift_q == key_q) && (ext_q == key_ext_q)) begin
                key_d     = '0;
                key_ext_d = 1'b0;
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end else begin
              key_d      = shift_q;
              key_ext_d  = ext_q;
              key_make_d = 1'b1;
              ext_d      = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign key        = key_q;
  assign key_ext    = key_ext_q;
  assign key_make   = key_make_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a frame-level reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_ps2_key_decoder;

  localparam int unsigned T    = 1000;
  localparam int unsigned S    = 2;
  localparam int          HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic [7:0] key;
  logic       key_ext;
  logic       key_make;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .code(code), .code_valid(code_valid), .key(key), .key_ext(key_ext),
    .key_make(key_make), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int err_cyc = 0;
  int cv_cnt = 0, km_cnt = 0, fe_cnt = 0;
  bit chk_en = 1'b0;
  int printed = 0;

  always @(posedge clk) cyc++;

  // Reference model: receiver works on whole bit lists, keys on byte rules
  bit        pc[$], pd[$];
  bit        m_prev, m_active;
  bit        bits[$];
  int        m_cnt;
  bit        m_ext, m_brk;
  logic [7:0] m_code, m_key;
  bit        m_cv, m_kext, m_km, m_fe;

  task automatic m_byte(input logic [7:0] b);
    m_code = b;
    m_cv   = 1'b1;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      if (b == m_key && m_ext == m_kext) begin
        m_key  = 8'h00;
        m_kext = 1'b0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_key  = b;
      m_kext = m_ext;
      m_km   = 1'b1;
      m_ext  = 1'b0;
    end
  endtask

  task automatic m_frame_done();
    logic [7:0] b;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = bits[i];
      ones += int'(bits[i]);
    end
    ones += int'(bits[8]);
    if (bits[9] && (ones % 2 == 1)) m_byte(b);
    else begin
      m_fe  = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    bit sc, sd, fall;
    m_cv = 1'b0; m_km = 1'b0; m_fe = 1'b0;
    if (!rst) begin
      pc.delete(); pd.delete();
      for (int i = 0; i < S; i++) begin pc.push_back(1'b1); pd.push_back(1'b1); end
      m_prev = 1'b1; m_active = 1'b0; bits.delete(); m_cnt = 0;
      m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00; m_key = 8'h00; m_kext = 1'b0;
    end else begin
      sc   = pc[S-1];
      sd   = pd[S-1];
      fall = m_prev && !sc;
      if (fall) begin
        m_cnt = 0;
        if (!m_active) begin
          if (!sd) begin m_active = 1'b1; bits.delete(); end
        end else begin
          bits.push_back(sd);
          if (bits.size() == 10) begin
            m_frame_done();
            m_active = 1'b0;
          end
        end
      end else if (!m_active) begin
        m_cnt = 0;
      end else if (m_cnt == int'(T) - 1) begin
        m_fe = 1'b1; m_active = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_prev = sc;
      pc.push_front(kb_clk); void'(pc.pop_back());
      pd.push_front(kb_data); void'(pd.pop_back());
    end
  end

  // Per-cycle comparison against the model plus pulse bookkeeping
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({code, code_valid, key, key_ext, key_make, frame_err} !==
          {m_code, m_cv, m_key, m_kext, m_km, m_fe}) begin
        fails++;
        if (printed < 10) begin
          printed++;
          $display("FAIL cycle_cmp @%0d: got code=%h cv=%b key=%h ext=%b mk=%b fe=%b, expected code=%h cv=%b key=%h ext=%b mk=%b fe=%b",
                   cyc, code, code_valid, key, key_ext, key_make, frame_err,
                   m_code, m_cv, m_key, m_kext, m_km, m_fe);
        end
      end
      if (code_valid) cv_cnt++;
      if (key_make) km_cnt++;
      if (frame_err) begin fe_cnt++; err_cyc = cyc; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_range(input logic [10:0] f, input int lo, input int hi, input int half);
    for (int i = lo; i <= hi; i++) begin
      kb_data = f[i];
      repeat (half) @(negedge clk);
      kb_clk   = 1'b0;
      fall_cyc = cyc;
      repeat (half) @(negedge clk);
      kb_clk = 1'b1;
    end
    repeat (half) @(negedge clk);
    kb_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_range(mk(b, 1'b0, 1'b1), 0, 10, HALF);
    repeat (30) @(negedge clk);
  endtask

  task automatic clr();
    cv_cnt = 0; km_cnt = 0; fe_cnt = 0;
  endtask

  initial begin
    logic [10:0] f;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({code, code_valid, key, key_ext, key_make, frame_err}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Slow frame: 8 us between bit edges
    clr();
    send_range(mk(8'h1D, 1'b0, 1'b1), 0, 10, 200);
    repeat (40) @(negedge clk);
    check("t1_code", int'(code), 'h1D);
    check("t1_key", int'(key), 'h1D);
    check("t1_key_ext", int'(key_ext), 0);
    check("t1_cv_pulses", cv_cnt, 1);
    check("t1_make_pulses", km_cnt, 1);

    clr();
    send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
    check("t2_key", int'(key), 0);
    check("t2_cv_pulses", cv_cnt, 3);
    check("t2_make_pulses", km_cnt, 1);

    send_byte(8'hE0); send_byte(8'h75);
    check("t3_key_down", int'(key), 'h75);
    check("t3_ext_down", int'(key_ext), 1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("t3_key_up", int'(key), 0);
    check("t3_ext_up", int'(key_ext), 0);

    send_byte(8'h1D);
    clr();
    send_range(mk(8'h29, 1'b1, 1'b1), 0, 10, HALF);
    repeat (30) @(negedge clk);
    check("t4_par_err", fe_cnt, 1);
    check("t4_par_cv", cv_cnt, 0);
    check("t4_par_key", int'(key), 'h1D);
    check("t4_par_code", int'(code), 'h1D);
    clr();
    send_range(mk(8'h29, 1'b0, 1'b0), 0, 10, HALF);
    repeat (30) @(negedge clk);
    check("t4_stop_err", fe_cnt, 1);
    check("t4_stop_cv", cv_cnt, 0);
    check("t4_stop_key", int'(key), 'h1D);

    clr();
    send_range(mk(8'h29, 1'b0, 1'b1), 0, 4, HALF);
    repeat (T + 50) @(negedge clk);
    check("t5_timeout_err", fe_cnt, 1);
    check("t5_timeout_delay", err_cyc - fall_cyc, int'(T + S + 1));
    send_byte(8'h29);
    check("t5_key_after", int'(key), 'h29);

    clr();
    f = mk(8'h1C, 1'b0, 1'b1);
    send_range(f, 0, 5, HALF);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t6_reset_outputs", int'({code, code_valid, key, key_ext, key_make, frame_err}), 0);
    send_range(f, 6, 10, HALF);
    repeat (T + 50) @(negedge clk);
    check("t6_no_cv", cv_cnt, 0);
    send_byte(8'h1C);
    check("t6_key_clean", int'(key), 'h1C);
    check("t6_code_clean", int'(code), 'h1C);
    check("t6_cv_clean", cv_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
